// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, register count and types for the gpr_rf register file.
package gpr_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [4:0] ZERO_REG = 5'd0;
    typedef logic [ADDR_W-1:0] gpr_addr_t;
    typedef logic [DATA_W-1:0] gpr_data_t;
endpackage

// File: rtl/gpr_read_port.sv
// gpr_read_port: one combinational read port with r0 forced to zero.
// Optional write-to-read forwarding when GPR_BYPASS_EN is defined.
module gpr_read_port #(
    parameter int DATA_W = gpr_pkg::DATA_W,
    parameter int ADDR_W = gpr_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
    input  logic                                wen,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    output logic [DATA_W-1:0]                   data
);
    import gpr_pkg::*;
    logic is_zero;
    assign is_zero = addr == ADDR_W'(ZERO_REG);
`ifdef GPR_BYPASS_EN
    // wen already excludes reset and writes to r0.
    assign data = is_zero ? '0 : (wen && addr == waddr) ? wdata : regs[addr];
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, wen, waddr, wdata};
    assign data = is_zero ? '0 : regs[addr];
`endif
endmodule

// File: rtl/gpr_rf.sv
// gpr_rf: 32x32 MIPS-lite register file, two combinational read ports, one synchronous write port.
// r0 hardwired to zero; define GPR_BYPASS_EN for same-cycle write-to-read forwarding.
module gpr_rf #(
    parameter int DATA_W = gpr_pkg::DATA_W,
    parameter int ADDR_W = gpr_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SIG_RF_W,
    input  logic [ADDR_W-1:0] reg_read1,
    input  logic [ADDR_W-1:0] reg_read2,
    input  logic [ADDR_W-1:0] reg_write,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2
);
    import gpr_pkg::*;
    localparam int N_REGS = 2**ADDR_W;
    logic [DATA_W-1:0]             regs [1:N_REGS-1];
    logic [N_REGS-1:0][DATA_W-1:0] rf_view;
    logic                          wen;
    // Anything other than a clean 1 on SIG_RF_W is treated as no-write.
    assign wen = rst && (SIG_RF_W == 1'b1) && (reg_write != ADDR_W'(ZERO_REG));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < N_REGS; k++) regs[k] <= '0;
        end else if (wen) begin
            regs[reg_write] <= data_write;
        end
    end
    always_comb begin
        rf_view = '0;
        for (int k = 1; k < N_REGS; k++) rf_view[k] = regs[k];
    end
    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .addr(reg_read1), .regs(rf_view), .wen(wen),
        .waddr(reg_write), .wdata(data_write), .data(reg_data1)
    );
    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .addr(reg_read2), .regs(rf_view), .wen(wen),
        .waddr(reg_write), .wdata(data_write), .data(reg_data2)
    );
endmodule

// File: tb/tb_gpr_rf.sv
// tb_gpr_rf: directed plus randomized checks of gpr_rf against an array model of the register file.
module tb_gpr_rf;
    logic        clk = 1'b0;
    logic        rst;
    logic        SIG_RF_W;
    logic [4:0]  reg_read1, reg_read2, reg_write;
    logic [31:0] data_write, reg_data1, reg_data2;
    logic [31:0] m [32];
    int          n_cmp = 0;
    int          n_err = 0;

    gpr_rf dut (
        .clk(clk), .rst(rst), .SIG_RF_W(SIG_RF_W),
        .reg_read1(reg_read1), .reg_read2(reg_read2), .reg_write(reg_write),
        .data_write(data_write), .reg_data1(reg_data1), .reg_data2(reg_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value from the model and the current write-port inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
`ifdef GPR_BYPASS_EN
        if (rst === 1'b1 && SIG_RF_W === 1'b1 && reg_write != 5'd0 && ra == reg_write)
            return data_write;
`endif
        return m[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
    endtask

    initial begin
        logic [4:0] probe [3];
        probe[0] = 5'd0; probe[1] = 5'd1; probe[2] = 5'd31;
        clear_model();
        rst = 1'b0; SIG_RF_W = 1'b1; reg_write = 5'd1; data_write = 32'h0000_0233;
        reg_read1 = 5'd0; reg_read2 = 5'd0;
        #100;
        for (int i = 0; i < 3; i++) begin
            reg_read1 = probe[i]; reg_read2 = probe[i];
            #1;
            chk("reset_rd1", reg_data1, 32'h0);
            chk("reset_rd2", reg_data2, 32'h0);
        end

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        m[1] = 32'h0000_0233;
        SIG_RF_W = 1'b0; reg_read1 = 5'd1;
        #1 chk("basic_write", reg_data1, 32'h0000_0233);

        @(negedge clk);
        SIG_RF_W = 1'b1; reg_write = 5'd0; data_write = 32'h0000_0233; reg_read2 = 5'd0;
        @(posedge clk); #1;
        chk("r0_hardwired", reg_data2, 32'h0);

        @(negedge clk);
        SIG_RF_W = 1'b0; reg_write = 5'd1; data_write = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("write_disable", reg_data1, 32'h0000_0233);

        @(negedge clk);
        SIG_RF_W = 1'b1; reg_write = 5'd5; data_write = 32'h1234_5678;
        @(negedge clk);
        reg_write = 5'd31; data_write = 32'hFFFF_FFFF;
        @(negedge clk);
        SIG_RF_W = 1'b0; reg_read1 = 5'd5; reg_read2 = 5'd31;
        #1;
        chk("dual_rd1", reg_data1, 32'h1234_5678);
        chk("dual_rd2", reg_data2, 32'hFFFF_FFFF);
        #1 rst = 1'b0;
        #1;
        chk("midreset_rd1", reg_data1, 32'h0);
        chk("midreset_rd2", reg_data2, 32'h0);
        clear_model();
        #1 rst = 1'b1;

        @(negedge clk);
        SIG_RF_W = 1'b1; reg_write = 5'd7; data_write = 32'hA5A5_A5A5; reg_read1 = 5'd7;
        #1;
`ifdef GPR_BYPASS_EN
        chk("rw_same_pre", reg_data1, 32'hA5A5_A5A5);
`else
        chk("rw_same_pre", reg_data1, 32'h0);
`endif
        @(posedge clk); #1;
        m[7] = 32'hA5A5_A5A5;
        chk("rw_same_post", reg_data1, 32'hA5A5_A5A5);

        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            SIG_RF_W = ($urandom_range(0, 3) != 0);
`ifndef GPR_BYPASS_EN
            if ($urandom_range(0, 9) == 0) SIG_RF_W = 1'bx;
`endif
            reg_write  = 5'($urandom);
            data_write = $urandom;
            reg_read1  = ($urandom_range(0, 2) == 0) ? reg_write : 5'($urandom);
            reg_read2  = ($urandom_range(0, 2) == 0) ? reg_write : 5'($urandom);
            #1;
            chk("rand_pre_rd1", reg_data1, exp_rd(reg_read1));
            chk("rand_pre_rd2", reg_data2, exp_rd(reg_read2));
            @(posedge clk);
            if (SIG_RF_W === 1'b1 && reg_write != 5'd0) m[reg_write] = data_write;
            #1;
            chk("rand_post_rd1", reg_data1, exp_rd(reg_read1));
            chk("rand_post_rd2", reg_data2, exp_rd(reg_read2));
        end

        SIG_RF_W = 1'b0;
        for (int i = 0; i < 32; i++) begin
            reg_read1 = 5'(i); reg_read2 = 5'(31 - i);
            #1;
            chk("sweep_rd1", reg_data1, m[i]);
            chk("sweep_rd2", reg_data2, m[31 - i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpr_rf.md
Name: gpr_rf

Overview:
- MIPS-lite general-purpose register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Sits in the datapath between instruction decode (register addresses) and the ALU/writeback stage (data_write).
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and data bus width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- SIG_RF_W  input  1  write enable from control unit.
- reg_read1  input  ADDR_W  read port 1 address.
- reg_read2  input  ADDR_W  read port 2 address.
- reg_write  input  ADDR_W  write address.
- data_write  input  DATA_W  write data.
- reg_data1  output  DATA_W  read port 1 data.
- reg_data2  output  DATA_W  read port 2 data.
- Port order for positional instantiation is exactly the list above.

Behaviour:
- Storage: registers r1..r31, each DATA_W bits. r0 is not stored and is constant 0.
- Reset:
  - rst low asynchronously forces r1..r31 to 0, regardless of clk.
  - While rst is low, writes are blocked.
  - Reset asserted mid-write: reset wins and the register stays 0.
  - Release is synchronous-safe: the first write is honoured on the first rising edge with rst high.
- Write:
  - On a rising clk edge with rst high, SIG_RF_W=1 and reg_write != 0, the register at reg_write takes data_write.
  - A write to address 0 is silently discarded.
  - SIG_RF_W=0 leaves all registers unchanged.
  - Latency: the value is visible on read ports combinationally right after that edge.
- Read:
  - Purely combinational, zero latency. reg_dataN = 0 if reg_readN == 0, else the content of register reg_readN.
  - Both ports are independent; the same address on both ports returns the same value.
  - Outputs read 0 for every address during and immediately after reset.
- Read-during-write, same address, same cycle (bypass disabled): read returns the old content until the clock edge, then the new one.
- X-safety: an undefined SIG_RF_W must not corrupt registers; treat any value other than 1 as no-write.

Optional Feature:
- Macro GPR_BYPASS_EN.
- Defined: write-to-read forwarding. If SIG_RF_W=1, rst high, reg_write != 0 and reg_readN == reg_write, then reg_dataN = data_write combinationally, in the same cycle as the write. Read address 0 is never forwarded.
- Not defined: no forwarding; reads always return stored content, as described under Behaviour.

Decomposition:
- Shared package gpr_pkg contains:
  - DATA_W and ADDR_W defaults.
  - NUM_REGS.
  - ZERO_REG = 5'd0.
  - Typedef gpr_addr_t (logic [ADDR_W-1:0]).
  - Typedef gpr_data_t (logic [DATA_W-1:0]).
- One natural sub-module, gpr_read_port, instantiated twice:
  - Inputs: address, register array view, and the write-bypass inputs.
  - Implements the read mux, the r0 zero forcing and the optional GPR_BYPASS_EN forwarding.

Test Plan:
- Reset: rst=0 for 100 ns with writes attempted (SIG_RF_W=1, reg_write=1, data_write=0x0000_0233) -> reg_data1/2 read 0 for addresses 0, 1 and 31.
- Basic write/read: rst=1, SIG_RF_W=1, reg_write=1, data_write=0x0000_0233, one edge; then SIG_RF_W=0, reg_read1=1 -> reg_data1=0x0000_0233.
- r0 hardwired: SIG_RF_W=1, reg_write=0, data_write=0x0000_0233, one edge; reg_read2=0 -> reg_data2=0x0000_0000.
- Write disable: SIG_RF_W=0, reg_write=1, data_write=0xDEAD_BEEF, one edge -> reg_data1 (addr 1) stays 0x0000_0233.
- Dual read and mid-run reset:
  - Write r5=0x1234_5678 and r31=0xFFFF_FFFF; read addr 5 on port 1 and 31 on port 2 -> both values are correct simultaneously.
  - Pulse rst=0 between clock edges -> both ports read 0 immediately.
- Same-cycle read/write to r7 with data 0xA5A5_A5A5:
  - Without GPR_BYPASS_EN: old value 0 before the edge, 0xA5A5_A5A5 after.
  - With GPR_BYPASS_EN: 0xA5A5_A5A5 already before the edge.
